dht11_sensor_emu: RTL and testbench
===================================

Name: dht11_sensor_emu

Overview:
- Emulates a DHT11 sensor on the single-wire open-drain bus: the responder end of the DHT11 read protocol.
- Detects a host start pulse, then drives the response preamble and a 40-bit frame (humidity int/dec, temperature int/dec, checksum).
- Used for on-board loopback and bench verification of the DHT11 host controller, with no physical sensor attached.

Parameters:
- CLKS_PER_US, 100, clk cycles per 1 µs timing tick (100 MHz clock).
- START_MIN_US, 18000, minimum host low time accepted as a valid start.
- RESP_DLY_US, 30, delay from host release to sensor pulling low.
- PRE_LOW_US, 80, response low phase.
- PRE_HIGH_US, 80, response high phase.
- BIT_LOW_US, 50, low phase before every data bit, and the trailing end low.
- BIT0_HIGH_US, 26, high time encoding 0.
- BIT1_HIGH_US, 70, high time encoding 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dht_io  inout  1  open-drain bus: driven 0 or released (z), never driven 1
- humid_int  in  8  humidity integer byte
- humid_dec  in  8  humidity decimal byte
- temp_int  in  8  temperature integer byte
- temp_dec  in  8  temperature decimal byte
- busy  out  1  high from start-pulse acceptance until the frame ends
- frame_done  out  1  one-cycle pulse after the trailing low is released

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: bus released (z), busy=0, frame_done=0, state IDLE, all counters 0. Reset asserted mid-frame releases the bus on the next clk edge; no partial frame resumes.
- Bus input: dht_io passes through a 2-FF synchronizer (2-cycle latency) before any decision.
- Timebase: a prescaler counts CLKS_PER_US cycles per µs tick and restarts on every state change. Each phase of N µs therefore lasts exactly N*CLKS_PER_US clk cycles.
- State machine (phase ends when its µs counter reaches its parameter):
  - IDLE: on a synced falling edge -> HOST_LOW.
  - HOST_LOW: counts µs while synced line is low; saturates at START_MIN_US. On the rising edge: if count ≥ START_MIN_US -> RESP_DLY, latch the four data bytes, compute checksum, busy=1; else glitch -> IDLE.
  - RESP_DLY: bus released for RESP_DLY_US -> PRE_LOW.
  - PRE_LOW: drive 0 for PRE_LOW_US -> PRE_HIGH.
  - PRE_HIGH: release for PRE_HIGH_US -> BIT_LOW.
  - BIT_LOW: drive 0 for BIT_LOW_US -> BIT_HIGH.
  - BIT_HIGH: release for BIT0_HIGH_US or BIT1_HIGH_US per the current bit, then increment bit index. Index 40 -> END_LOW; else -> BIT_LOW.
  - END_LOW: drive 0 for BIT_LOW_US, release -> IDLE; busy=0; frame_done=1 for one cycle.
- Frame order: {humid_int, humid_dec, temp_int, temp_dec, checksum}, 40 bits, MSB first.
- Checksum: low 8 bits of the 10-bit sum of the four latched bytes; carry discarded.
- Input bytes change freely while busy; only the values latched at start acceptance are sent.
- Bus activity while busy (host or contention) is ignored; the frame always completes. A new start is only recognised from IDLE.
- Line held low indefinitely in HOST_LOW: stays there with no timeout; response begins only on release.

Optional Feature:
- Macro: CKSUM_ERR_INJ_EN.
- Defined: adds input port cksum_err (1 bit), sampled at start acceptance. If 1, the transmitted checksum is the bitwise inverse of the correct value, so the host's validity check fails.
- Undefined: no cksum_err port; checksum is always correct.

Test Plan:
- Bytes 0x37,0x00,0x19,0x05; host low 18 ms then release -> first bus low 30 µs after release. Decoded frame 0x3700190555 (checksum 0x55); frame_done pulses once; busy low afterwards.
- Host low 10 µs with START_MIN_US=18000 -> no bus drive, busy stays 0, state IDLE.
- Bytes 0xFF,0xFF,0xFF,0xFF -> checksum 0xFC (carry discarded). Every bit high phase measures 70*CLKS_PER_US = 7000 clk cycles; low phases 5000 cycles.
- Change humid_int from 0x37 to 0x10 mid-frame -> transmitted frame still carries 0x37.
- Assert rst during bit 12 -> bus released the next cycle, busy=0, no frame_done. A fresh 18 ms start afterwards yields a complete correct frame.
- CKSUM_ERR_INJ_EN defined, cksum_err=1, bytes 0x37,0x00,0x19,0x05 -> checksum byte 0xAA; the host controller reports not valid.

Source files
------------

// File: rtl/dht11_if.sv
// dht11_if: byte inputs and status outputs of the DHT11 sensor emulator.
// With CKSUM_ERR_INJ_EN defined the cksum_err request line is added.
interface dht11_if;
   logic [7:0] humid_int;
   logic [7:0] humid_dec;
   logic [7:0] temp_int;
   logic [7:0] temp_dec;
   logic       busy;
   logic       frame_done;
`ifdef CKSUM_ERR_INJ_EN
   logic       cksum_err;

   modport master (
      output humid_int, humid_dec, temp_int, temp_dec, cksum_err,
      input  busy, frame_done
   );
   modport slave (
      input  humid_int, humid_dec, temp_int, temp_dec, cksum_err,
      output busy, frame_done
   );
`else
   modport master (
      output humid_int, humid_dec, temp_int, temp_dec,
      input  busy, frame_done
   );
   modport slave (
      input  humid_int, humid_dec, temp_int, temp_dec,
      output busy, frame_done
   );
`endif
endinterface

// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: DHT11 responder on an open-drain single-wire bus.
// Optional CKSUM_ERR_INJ_EN: cksum_err=1 at start sends an inverted checksum.
module dht11_sensor_emu #(
   parameter int CLKS_PER_US  = 100,
   parameter int START_MIN_US = 18000,
   parameter int RESP_DLY_US  = 30,
   parameter int PRE_LOW_US   = 80,
   parameter int PRE_HIGH_US  = 80,
   parameter int BIT_LOW_US   = 50,
   parameter int BIT0_HIGH_US = 26,
   parameter int BIT1_HIGH_US = 70
) (
   input  logic   clk,
   input  logic   rst,
   inout  wire    dht_io,
   dht11_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, HOST_LOW, RESP_DLY, PRE_LOW,
      PRE_HIGH, BIT_LOW, BIT_HIGH, END_LOW
   } state_t;

   localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
   localparam int UW = $clog2(START_MIN_US + 256);

   state_t        state;
   logic [PW-1:0] pre;
   logic [UW-1:0] us;
   logic [UW-1:0] lim;
   logic [39:0]   frame;
   logic [5:0]    bit_idx;
   logic          drive_low;
   logic          sync1, sync2, line_q;
   logic          busy_q, done_q;
   logic          tick, fall, rise, phase_end;
   logic [7:0]    sum8, cksum;

   assign dht_io         = drive_low ? 1'b0 : 1'bz;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;

   assign tick      = (pre == PW'(CLKS_PER_US - 1));
   assign fall      = line_q & ~sync2;
   assign rise      = ~line_q & sync2;
   assign phase_end = tick && (us == lim);

   assign sum8 = bus.humid_int + bus.humid_dec
               + bus.temp_int + bus.temp_dec;
`ifdef CKSUM_ERR_INJ_EN
   assign cksum = bus.cksum_err ? ~sum8 : sum8;
`else
   assign cksum = sum8;
`endif

   always_comb begin
      lim = '0;
      unique case (state)
         RESP_DLY: lim = UW'(RESP_DLY_US - 1);
         PRE_LOW:  lim = UW'(PRE_LOW_US - 1);
         PRE_HIGH: lim = UW'(PRE_HIGH_US - 1);
         BIT_LOW:  lim = UW'(BIT_LOW_US - 1);
         END_LOW:  lim = UW'(BIT_LOW_US - 1);
         BIT_HIGH: lim = frame[39] ? UW'(BIT1_HIGH_US - 1)
                                   : UW'(BIT0_HIGH_US - 1);
         default:  lim = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pre       <= '0;
         us        <= '0;
         frame     <= '0;
         bit_idx   <= '0;
         drive_low <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         line_q    <= 1'b1;
      end else begin
         sync1  <= dht_io;
         sync2  <= sync1;
         line_q <= sync2;
         done_q <= 1'b0;
         pre    <= tick ? '0 : pre + 1'b1;
         // HOST_LOW saturates so an endless low cannot wrap the count
         if (tick && state != IDLE &&
             !(state == HOST_LOW && us >= UW'(START_MIN_US)))
            us <= us + 1'b1;
         unique case (state)
            IDLE: if (fall) begin
               state <= HOST_LOW;
               pre   <= '0;
               us    <= '0;
            end
            HOST_LOW: if (rise) begin
               pre <= '0;
               us  <= '0;
               if (us >= UW'(START_MIN_US)) begin
                  state   <= RESP_DLY;
                  frame   <= {bus.humid_int, bus.humid_dec,
                              bus.temp_int, bus.temp_dec, cksum};
                  bit_idx <= '0;
                  busy_q  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            RESP_DLY: if (phase_end) begin
               state     <= PRE_LOW;
               drive_low <= 1'b1;
               pre       <= '0;
               us        <= '0;
            end
            PRE_LOW: if (phase_end) begin
               state     <= PRE_HIGH;
               drive_low <= 1'b0;
               pre       <= '0;
               us        <= '0;
            end
            PRE_HIGH: if (phase_end) begin
               state     <= BIT_LOW;
               drive_low <= 1'b1;
               pre       <= '0;
               us        <= '0;
            end
            BIT_LOW: if (phase_end) begin
               state     <= BIT_HIGH;
               drive_low <= 1'b0;
               pre       <= '0;
               us        <= '0;
            end
            BIT_HIGH: if (phase_end) begin
               state     <= (bit_idx == 6'd39) ? END_LOW : BIT_LOW;
               frame     <= {frame[38:0], 1'b0};
               bit_idx   <= bit_idx + 1'b1;
               drive_low <= 1'b1;
               pre       <= '0;
               us        <= '0;
            end
            END_LOW: if (phase_end) begin
               state     <= IDLE;
               drive_low <= 1'b0;
               busy_q    <= 1'b0;
               done_q    <= 1'b1;
               pre       <= '0;
               us        <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dht11_sensor_emu.sv
// tb_dht11_sensor_emu: directed host-side stimulus and frame decoding
// for the DHT11 sensor emulator, with scaled timing parameters.
module tb_dht11_sensor_emu;
   localparam int CPU   = 2;
   localparam int START = 50;
   localparam int LIMIT = 1000;

   logic clk = 1'b0;
   logic rst;
   logic host_low;
   wire  dht_io;

   dht11_if bus_if ();

   assign dht_io = host_low ? 1'b0 : 1'bz;
   pullup (dht_io);

   dht11_sensor_emu #(
      .CLKS_PER_US  (CPU),
      .START_MIN_US (START),
      .RESP_DLY_US  (30),
      .PRE_LOW_US   (80),
      .PRE_HIGH_US  (80),
      .BIT_LOW_US   (50),
      .BIT0_HIGH_US (26),
      .BIT1_HIGH_US (70)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .dht_io (dht_io),
      .bus    (bus_if.slave)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;
   int   falls    = 0;
   logic line_prev = 1'b1;

   always @(negedge clk) begin
      if (bus_if.frame_done === 1'b1) done_cnt++;
      if (line_prev === 1'b1 && dht_io === 1'b0) falls++;
      line_prev = dht_io;
   end

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic host_start(input int us_low);
      @(negedge clk);
      host_low = 1'b1;
      repeat (us_low * CPU) @(negedge clk);
      host_low = 1'b0;
   endtask

   task automatic meas(input logic lvl, output int n);
      n = 0;
      while (dht_io === lvl && n < LIMIT) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic rx_frame(output logic [39:0] d, output int dly,
                           output int plo, output int phi,
                           output int elo,
                           output int lmin, output int lmax,
                           output int hmin, output int hmax);
      int n;
      d = '0; dly = 0;
      lmin = LIMIT; lmax = 0; hmin = LIMIT; hmax = 0;
      do begin
         @(negedge clk);
         dly++;
      end while (dht_io !== 1'b0 && dly < LIMIT);
      meas(1'b0, plo);
      meas(1'b1, phi);
      for (int i = 0; i < 40; i++) begin
         meas(1'b0, n);
         if (n < lmin) lmin = n;
         if (n > lmax) lmax = n;
         meas(1'b1, n);
         if (i < 32 && n < hmin) hmin = n;
         if (i < 32 && n > hmax) hmax = n;
         d = {d[38:0], (n > 96)};
      end
      meas(1'b0, elo);
   endtask

   task automatic set_bytes(input logic [31:0] b);
      bus_if.humid_int = b[31:24];
      bus_if.humid_dec = b[23:16];
      bus_if.temp_int  = b[15:8];
      bus_if.temp_dec  = b[7:0];
   endtask

   logic [39:0] d;
   int dly, plo, phi, elo, lmin, lmax, hmin, hmax;
   int d0, f0, n, lows, busys;

   initial begin
      rst = 1'b1;
      host_low = 1'b0;
      set_bytes(32'h37001905);
`ifdef CKSUM_ERR_INJ_EN
      bus_if.cksum_err = 1'b0;
`endif
      repeat (5) @(negedge clk);
      check("rst_bus", dht_io, 1'b1);
      check("rst_busy", bus_if.busy, 1'b0);
      check("rst_done", bus_if.frame_done, 1'b0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // basic frame
      d0 = done_cnt;
      host_start(START + 5);
      rx_frame(d, dly, plo, phi, elo, lmin, lmax, hmin, hmax);
      check("resp_dly", dly, 63);
      check("pre_low", plo, 160);
      check("pre_high", phi, 160);
      check("frame_37", d, 40'h3700190555);
      check("end_low", elo, 100);
      repeat (5) @(negedge clk);
      check("done_once", done_cnt - d0, 1);
      check("busy_after", bus_if.busy, 1'b0);

      // short low pulse is a glitch
      host_start(10);
      lows = 0; busys = 0;
      repeat (300) begin
         @(negedge clk);
         if (dht_io === 1'b0) lows++;
         if (bus_if.busy === 1'b1) busys++;
      end
      check("glitch_lows", lows, 0);
      check("glitch_busy", busys, 0);

      // all ones, checksum carry dropped
      set_bytes(32'hFFFFFFFF);
      host_start(START + 5);
      rx_frame(d, dly, plo, phi, elo, lmin, lmax, hmin, hmax);
      check("frame_ff", d, 40'hFFFFFFFFFC);
      check("ff_lmin", lmin, 100);
      check("ff_lmax", lmax, 100);
      check("ff_hmin", hmin, 140);
      check("ff_hmax", hmax, 140);

      // input change while busy is not sent
      set_bytes(32'h37001905);
      host_start(START + 5);
      fork
         rx_frame(d, dly, plo, phi, elo, lmin, lmax, hmin, hmax);
         begin
            repeat (2000) @(negedge clk);
            bus_if.humid_int = 8'h10;
         end
      join
      check("frame_latched", d, 40'h3700190555);
      check("busy_mid_done", bus_if.busy, 1'b0);
      bus_if.humid_int = 8'h37;
      repeat (10) @(negedge clk);

      // reset during bit 12
      host_start(START + 5);
      f0 = falls;
      n = 0;
      while (falls < f0 + 14 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("bit12_reached", falls - f0, 14);
      repeat (20) @(negedge clk);
      check("bit12_low", dht_io, 1'b0);
      d0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_bus", dht_io, 1'b1);
      check("rst_mid_busy", bus_if.busy, 1'b0);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      check("rst_mid_nodone", done_cnt - d0, 0);

      // fresh frame after the aborted one
      d0 = done_cnt;
      host_start(START + 5);
      rx_frame(d, dly, plo, phi, elo, lmin, lmax, hmin, hmax);
      check("frame_fresh", d, 40'h3700190555);
      repeat (5) @(negedge clk);
      check("fresh_done", done_cnt - d0, 1);

`ifdef CKSUM_ERR_INJ_EN
      bus_if.cksum_err = 1'b1;
      host_start(START + 5);
      rx_frame(d, dly, plo, phi, elo, lmin, lmax, hmin, hmax);
      check("frame_cksum_err", d, 40'h37001905AA);
      bus_if.cksum_err = 1'b0;
      repeat (5) @(negedge clk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
